s2p_word_fifo: RTL
==================

# s2p_word_fifo

Word buffer directly downstream of the serial-to-parallel converter. Captures each DATA_WIDTH-bit word presented with a one-cycle valid pulse into a DEPTH-entry circular store and presents the words in arrival order on a ready/valid read port. The converter has no backpressure, so words arriving while full are dropped and flagged. This block decouples the converter's bursty output from the consumer's read rate.

## Interface

**Parameters**
- DATA_WIDTH, 64, word width; matches the converter's data_out.
- ADDRESS_WIDTH, 3, pointer width.
- DEPTH, 2**ADDRESS_WIDTH, number of entries; never overridden independently.

**Ports**
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  DATA_WIDTH  word from the converter's data_out.
- in_valid  input  1  one-cycle pulse; the word on in_data is offered this cycle.
- out_data  output  DATA_WIDTH  head-of-queue word (show-ahead); 0 when empty.
- out_valid  output  1  high when at least one word is stored.
- out_ready  input  1  consumer accepts out_data this cycle when out_valid is high.
- count  output  ADDRESS_WIDTH+1  number of stored words, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; set when a word is dropped, cleared only by rst.
- drop_count  output  8  saturating count of dropped words (see Configuration).

## Operation

- Storage: DEPTH x DATA_WIDTH array, write pointer wr_ptr and read pointer rd_ptr, each ADDRESS_WIDTH bits; both wrap DEPTH-1 -> 0 naturally. Stored data is not reset.
- Push: push = in_valid && (!full || pop).
  - On push, write in_data to mem[wr_ptr] and increment wr_ptr.
- Pop: pop = out_valid && out_ready.
  - On pop, increment rd_ptr.
  - out_ready while empty is ignored.
- count:
  - Increments on push without pop.
  - Decrements on pop without push.
  - Unchanged on both or neither.
- Simultaneous push and pop when full: both occur; count stays DEPTH, full stays high, and no drop occurs.
- Simultaneous push and pop when count == 1: the head is popped, the new word becomes the head next cycle, and count stays 1.
- Drop: in_valid && full && !pop.
  - The word is discarded and pointers are unchanged.
  - overflow is set on the next edge.
- out_data = mem[rd_ptr] when count != 0, else 0.
- out_valid = (count != 0); full = (count == DEPTH). Both are derived from registered count.
- Reset value of every output:
  - out_data = 0, out_valid = 0, count = 0, full = 0, overflow = 0, drop_count = 0.
  - wr_ptr and rd_ptr = 0.
- Reset mid-operation: all stored words are discarded. A push or pop coinciding with rst is ignored.

## Timing

- Write-to-read latency is 1 cycle: a word pushed at edge N appears on out_data with out_valid high after edge N.
- Pop takes effect at the edge where out_valid && out_ready. The next word (or empty) is visible after that edge.
- Back-to-back pushes every cycle are accepted until full. Sustained full-rate throughput is possible with out_ready held high.
- No combinational path from in_valid or in_data to any output. out_ready affects outputs only through registers.

## Configuration

- Macro: S2P_WORD_FIFO_DROP_STATS_EN.
- Defined:
  - drop_count increments by 1 on each drop and saturates at 255.
  - It is cleared only by rst.
- Undefined:
  - drop_count is tied to 0 and no counter is built.
  - overflow behaviour is unchanged.

## Test plan

- Reset, then 8 pulses of in_valid with in_data = 1..8 and out_ready low.
  - count reaches 8 and full = 1.
  - out_data = 1, overflow = 0.
- Fill to 8, then a 9th in_valid (0xDEAD) with out_ready low.
  - The word is dropped and overflow = 1.
  - With the macro defined, drop_count = 1.
  - Draining yields 1..8; 0xDEAD never appears.
- Full, then in_valid (0x9) with out_ready high in the same cycle.
  - Word 1 is popped and count stays 8.
  - No drop; the drain order ends in 9.
- Write 12 words through with out_ready high in every cycle (pointer wrap).
  - Output order is 1..12, each appearing 1 cycle after its push.
  - count never exceeds 1.
- Empty FIFO with out_ready held high, then one push of 0xA5.
  - out_valid pulses high for one cycle with out_data = 0xA5.
  - After the pop, out_data = 0 and out_valid = 0.
- Store 5 words, assert rst for one cycle coincident with in_valid.
  - count = 0 and out_valid = 0; overflow and drop_count are 0.
  - The next push appears as the head.

Source files
------------

// File: rtl/s2p_word_fifo.sv
// Circular word buffer behind the serial-to-parallel converter; show-ahead ready/valid read port.
// Define S2P_WORD_FIFO_DROP_STATS_EN to build the saturating drop_count counter.
module s2p_word_fifo #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 3,
  parameter int DEPTH         = 2**ADDRESS_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_WIDTH:0]  count,
  output logic                    full,
  output logic                    overflow,
  output logic [7:0]              drop_count
);
  localparam logic [ADDRESS_WIDTH:0] LP_DEPTH = (ADDRESS_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
  logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
  logic [ADDRESS_WIDTH:0]   r_count;
  logic                     r_overflow;

  logic w_empty, w_full, w_pop, w_push, w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_DEPTH);
  assign w_pop   = !w_empty && out_ready;
  // A pop frees a slot in the same edge, so a full buffer still accepts the word.
  assign w_push  = in_valid && (!w_full || w_pop);
  assign w_drop  = in_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push && !rst)
      r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

`ifdef S2P_WORD_FIFO_DROP_STATS_EN
  logic [7:0] r_drop_count;
  always_ff @(posedge clk) begin
    if (rst)
      r_drop_count <= '0;
    else if (w_drop && (r_drop_count != 8'hFF))
      r_drop_count <= r_drop_count + 8'd1;
  end
  assign drop_count = r_drop_count;
`else
  assign drop_count = '0;
`endif

  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign out_valid = !w_empty;
  assign count     = r_count;
  assign full      = w_full;
  assign overflow  = r_overflow;
endmodule
